// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - measures high width and rise-to-rise period of a synchronized pulse train
module pulse_width_meter #(
  parameter int CW = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          signal,
  input  logic          ack,
  output logic          valid,
  output logic [CW-1:0] width,
  output logic [CW-1:0] period,
  output logic          period_ok,
  output logic          sat,
  output logic          overrun
);

  localparam logic [1:0] WAIT_LOW = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] HIGH     = 2'd2;
  localparam logic [1:0] LOW      = 2'd3;

  localparam logic [CW-1:0] MAX = {CW{1'b1}};
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic          s1_q, s2_q, s3_q;
  logic [1:0]    fill_q, fill_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          have_prev_q, have_prev_d;
  logic          valid_q, valid_d;
  logic [CW-1:0] width_q, width_d;
  logic [CW-1:0] period_q, period_d;
  logic          period_ok_q, period_ok_d;
  logic          sat_q, sat_d;
  logic          overrun_q, overrun_d;
  logic          load;

  wire rise   = s2_q & ~s3_q;
  wire fall   = ~s2_q & s3_q;
  // s2 only reflects a real post-reset sample once two edges have passed
  wire primed = fill_q[1];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == MAX) ? x : x + ONE;
  endfunction

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    pcnt_d      = pcnt_q;
    hold_d      = hold_q;
    have_prev_d = have_prev_q;
    load        = 1'b0;
    fill_d      = primed ? fill_q : fill_q + 2'd1;
    case (state_q)
      WAIT_LOW: if (primed && !s2_q) state_d = ARMED;
      ARMED: begin
        if (rise) begin
          state_d     = HIGH;
          wcnt_d      = ONE;
          pcnt_d      = ONE;
          have_prev_d = 1'b0;
        end
      end
      HIGH: begin
        if (s2_q) begin
          wcnt_d = sat_inc(wcnt_q);
          pcnt_d = sat_inc(pcnt_q);
        end else if (fall) begin
          state_d = LOW;
          load    = 1'b1;
          pcnt_d  = sat_inc(pcnt_q);
        end
      end
      LOW: begin
        if (rise) begin
          state_d     = HIGH;
          hold_d      = pcnt_q;
          pcnt_d      = ONE;
          wcnt_d      = ONE;
          have_prev_d = 1'b1;
        end else begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    width_d     = width_q;
    period_d    = period_q;
    period_ok_d = period_ok_q;
    sat_d       = sat_q;
    overrun_d   = overrun_q;
    if (load) begin
      valid_d     = 1'b1;
      width_d     = wcnt_q;
      period_d    = hold_q;
      period_ok_d = have_prev_q;
      sat_d       = (wcnt_q == MAX) || (hold_q == MAX);
      // an ack on the load edge accepts the old result, so nothing is lost
      if (valid_q) overrun_d = ~ack;
    end else if (valid_q && ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      fill_q      <= 2'd0;
      state_q     <= WAIT_LOW;
      wcnt_q      <= '0;
      pcnt_q      <= '0;
      hold_q      <= '0;
      have_prev_q <= 1'b0;
      valid_q     <= 1'b0;
      width_q     <= '0;
      period_q    <= '0;
      period_ok_q <= 1'b0;
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      s1_q        <= signal;
      s2_q        <= s1_q;
      s3_q        <= s2_q;
      fill_q      <= fill_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      pcnt_q      <= pcnt_d;
      hold_q      <= hold_d;
      have_prev_q <= have_prev_d;
      valid_q     <= valid_d;
      width_q     <= width_d;
      period_q    <= period_d;
      period_ok_q <= period_ok_d;
      sat_q       <= sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign valid     = valid_q;
  assign width     = width_q;
  assign period    = period_q;
  assign period_ok = period_ok_q;
  assign sat       = sat_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - directed bench with a sample-stream model for pulse_width_meter
module tb_pulse_width_meter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, sig, man_ack, auto_ack, ack_auto, sig4, ack4, cmp_en;
  wire  ack_w = auto_ack ? ack_auto : man_ack;

  logic       valid, period_ok, sat, overrun;
  logic [7:0] width, period;
  logic       valid4, period_ok4, sat4, overrun4;
  logic [3:0] width4, period4;

  pulse_width_meter #(.CW(8)) dut (
    .clock(clock), .reset_n(reset_n), .signal(sig), .ack(ack_w),
    .valid(valid), .width(width), .period(period), .period_ok(period_ok),
    .sat(sat), .overrun(overrun)
  );

  pulse_width_meter #(.CW(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .signal(sig4), .ack(ack4),
    .valid(valid4), .width(width4), .period(period4), .period_ok(period_ok4),
    .sat(sat4), .overrun(overrun4)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: works on the raw sample stream; a pulse is a run of high samples
  // following a low sample seen since reset, reported two edges after its end.
  typedef struct packed {
    int         due;
    logic [7:0] w;
    logic [7:0] p;
    logic       ok;
    logic       st;
  } res_t;

  res_t pend[$];
  int   n = 0;
  bit   armed = 0, in_pulse = 0, have_rise = 0, cur_ok = 0;
  int   run_len = 0, last_rise = 0, cur_period = 0;
  logic       m_valid = 0, m_ok = 0, m_sat = 0, m_ovr = 0;
  logic [7:0] m_width = 0, m_period = 0;

  always @(posedge clock) begin
    n++;
    if (!reset_n) begin
      pend.delete();
      armed = 0; in_pulse = 0; have_rise = 0;
      m_valid = 0; m_ok = 0; m_sat = 0; m_ovr = 0; m_width = 0; m_period = 0;
    end else begin
      if (pend.size() > 0 && pend[0].due == n) begin
        if (m_valid) m_ovr = !ack_w;
        m_valid  = 1;
        m_width  = pend[0].w;
        m_period = pend[0].p;
        m_ok     = pend[0].ok;
        m_sat    = pend[0].st;
        void'(pend.pop_front());
      end else if (m_valid && ack_w) begin
        m_valid = 0;
        m_ovr   = 0;
      end
      if (!armed) begin
        if (!sig) armed = 1;
      end else if (in_pulse) begin
        if (sig) begin
          if (run_len < 255) run_len++;
        end else begin
          pend.push_back('{n + 2, 8'(run_len), 8'(cur_period), cur_ok,
                           (run_len == 255) || (cur_period == 255)});
          in_pulse = 0;
        end
      end else if (sig) begin
        in_pulse = 1;
        run_len  = 1;
        if (have_rise) begin
          cur_period = (n - last_rise > 255) ? 255 : n - last_rise;
          cur_ok     = 1;
        end else begin
          cur_period = 0;
          cur_ok     = 0;
        end
        last_rise = n;
        have_rise = 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (cmp_en) begin
        tests++;
        if (valid !== m_valid || width !== m_width || period !== m_period ||
            period_ok !== m_ok || sat !== m_sat || overrun !== m_ovr) begin
          fails++;
          $display("FAIL model_cmp t=%0t got v%0b w%0d p%0d ok%0b s%0b o%0b expected v%0b w%0d p%0d ok%0b s%0b o%0b",
                   $time, valid, width, period, period_ok, sat, overrun,
                   m_valid, m_width, m_period, m_ok, m_sat, m_ovr);
        end
      end
    end
  end

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] p;
    logic       ok;
    logic       st;
    logic       ov;
  } cap_t;
  cap_t cap[$];

  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clock);
      if (auto_ack && valid && !ack_auto) begin
        ack_auto = 1'b1;
        cap.push_back('{width, period, period_ok, sat, overrun});
      end else begin
        ack_auto = 1'b0;
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    sig = 1'b1;
    repeat (hi) @(negedge clock);
    sig = 1'b0;
    repeat (lo) @(negedge clock);
  endtask

  task automatic chk_cap(input string name, input int idx, input int w, input int p,
                         input int ok, input int st, input int ov);
    cap_t c;
    c = (idx < cap.size()) ? cap[idx] : '0;
    chk({name, "_width"}, int'(c.w), w);
    chk({name, "_period"}, int'(c.p), p);
    chk({name, "_ok"}, int'(c.ok), ok);
    chk({name, "_sat"}, int'(c.st), st);
    chk({name, "_ovr"}, int'(c.ov), ov);
  endtask

  initial begin
    reset_n = 0; sig = 0; sig4 = 0; man_ack = 0; auto_ack = 1; ack4 = 0; cmp_en = 0;
    repeat (3) @(negedge clock);
    cmp_en = 1;
    chk("rst_valid", int'(valid), 0);
    chk("rst_width", int'(width), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_ok", int'(period_ok), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_ovr", int'(overrun), 0);
    reset_n = 1;
    repeat (4) @(negedge clock);

    cap.delete();
    repeat (3) pulse(4, 6);
    repeat (6) @(negedge clock);
    chk("t1_count", cap.size(), 3);
    chk_cap("t1_r1", 0, 4, 0, 0, 0, 0);
    chk_cap("t1_r2", 1, 4, 10, 1, 0, 0);
    chk_cap("t1_r3", 2, 4, 10, 1, 0, 0);

    cap.delete();
    sig = 1;
    repeat (2) @(negedge clock);
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    repeat (4) @(negedge clock);
    sig = 0;
    repeat (3) @(negedge clock);
    pulse(5, 8);
    chk("t2_count", cap.size(), 1);
    chk_cap("t2_r1", 0, 5, 0, 0, 0, 0);

    sig4 = 1;
    repeat (20) @(negedge clock);
    sig4 = 0;
    for (int i = 0; i < 10 && !valid4; i++) @(negedge clock);
    chk("t3_valid4", int'(valid4), 1);
    chk("t3_width4", int'(width4), 15);
    chk("t3_sat4", int'(sat4), 1);
    chk("t3_ok4", int'(period_ok4), 0);
    chk("t3_ovr4", int'(overrun4), 0);

    auto_ack = 0;
    pulse(2, 4);
    pulse(3, 6);
    chk("t4_valid", int'(valid), 1);
    chk("t4_width", int'(width), 3);
    chk("t4_period", int'(period), 6);
    chk("t4_ok", int'(period_ok), 1);
    chk("t4_ovr", int'(overrun), 1);
    man_ack = 1;
    @(negedge clock);
    man_ack = 0;
    chk("t4_ack_valid", int'(valid), 0);
    chk("t4_ack_ovr", int'(overrun), 0);

    pulse(2, 4);
    chk("t5_first_width", int'(width), 2);
    sig = 1;
    repeat (3) @(negedge clock);
    sig = 0;
    @(negedge clock);
    @(negedge clock);
    chk("t5_hold_width", int'(width), 2);
    man_ack = 1;
    @(negedge clock);
    man_ack = 0;
    chk("t5_valid", int'(valid), 1);
    chk("t5_width", int'(width), 3);
    chk("t5_ovr", int'(overrun), 0);
    repeat (2) @(negedge clock);
    man_ack = 1;
    @(negedge clock);
    man_ack = 0;
    chk("t5_cleared", int'(valid), 0);
    repeat (3) @(negedge clock);

    auto_ack = 1;
    cap.delete();
    sig = 1;
    repeat (3) @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    reset_n = 1;
    repeat (3) @(negedge clock);
    sig = 0;
    repeat (5) @(negedge clock);
    chk("t6_no_result", cap.size(), 0);
    pulse(4, 6);
    repeat (4) @(negedge clock);
    chk("t6_count", cap.size(), 1);
    chk_cap("t6_r1", 0, 4, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
# pulse_width_meter

Synchronous receiver for the pulse trains produced by the team's pulse generators. It samples a single-bit `signal` input on `clock`, measures each high pulse width and the rising-edge-to-rising-edge period in clock cycles, and presents each result to a consumer. Results are held under a valid/ack handshake. It sits on the receive side of any pulse-generator output in the testbenches and datapaths, so generated waveforms can be checked in-circuit.

## Interface
- `CW`, default 8: width in bits of the width and period counters and of the result fields.
- `clock` input 1: sole clock; all state updates on its rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `signal` input 1: pulse input. Asynchronous to `clock`; passes through a 2-flop synchronizer.
- `ack` input 1: consumer accepts the current result.
- `valid` output 1: a result is held on `width`, `period`, `period_ok`, `sat`.
- `width` output CW: high-time of the last pulse, in cycles.
- `period` output CW: rise-to-rise distance, in cycles, from the previous pulse to this one.
- `period_ok` output 1: `period` is meaningful. It is 0 for the first pulse after reset.
- `sat` output 1: `width` or `period` saturated at 2^CW-1.
- `overrun` output 1: sticky. A result was overwritten before it was acked.

## Operation
- **Synchronizer chain:**
  - `s1` <= `signal`, `s2` <= `s1`, `s3` <= `s2`.
  - `rise` = `s2 & ~s3`; `fall` = `~s2 & s3`.
- **States:** WAIT_LOW, ARMED, HIGH, LOW.
  - WAIT_LOW is entered on reset. It moves to ARMED at the first edge with `s2`=0, so a pulse already in progress at reset release is never measured.
  - ARMED: on `rise`, go to HIGH with `wcnt`<=1 and `pcnt`<=1; `have_prev`<=0.
  - HIGH: `wcnt` and `pcnt` increment each edge while `s2`=1. On `fall`, go to LOW, load the result, and increment `pcnt`.
  - LOW: `pcnt` increments each edge. On `rise`, go to HIGH with `period_hold`<=`pcnt`, `pcnt`<=1, `wcnt`<=1 and `have_prev`<=1.
- **Result load (on `fall`):**
  - `width`<=`wcnt`, `period`<=`period_hold`, `period_ok`<=`have_prev`.
  - `sat`<=1 if `wcnt` or `period_hold` equals 2^CW-1.
  - `valid`<=1.
- **Counter width:** counters are CW bits and saturate at all-ones; they never wrap.
- **Handshake:**
  - `valid` stays high until an edge where `ack`=1; `valid` then clears.
  - `ack` while `valid`=0 is ignored.
- **Simultaneous events:**
  - Result load and `ack` in the same cycle: the new result is loaded, `valid` stays 1, and `overrun` is not set.
  - Result load while `valid`=1 and `ack`=0: the new result overwrites the old one and `overrun`<=1.
  - `overrun` clears on the next accepted `ack`.
- **Reset (any cycle, including mid-pulse):** all state returns to WAIT_LOW and the partial measurement is discarded.

## Timing
- **Reset values:** `valid`, `width`, `period`, `period_ok`, `sat`, `overrun` = 0; `s1`..`s3` = 0; state = WAIT_LOW.
- **Latency:** `signal` falling is first sampled low at edge k; `valid` rises at edge k+2. Same 2-edge latency from a rising sample to entering HIGH.
- **Width accuracy:** for synchronous input, `width` = exact number of edges at which `signal` was sampled high. `period` = edges between consecutive rising samples.
- **Minimum pulse:** 1 cycle high and 1 cycle low is measured correctly: `width`=1, `period`=2.
- **Result holding:** outputs change only on result load or reset; they are stable while `valid`=1.

## Test plan
- Reset, then drive `signal` high for 4 cycles and low for 6, three times, with `ack` pulsed after each `valid`:
  - results 1..3 have `width`=4 each;
  - result 1 has `period_ok`=0;
  - results 2 and 3 have `period`=10 and `period_ok`=1;
  - `sat`=0 and `overrun`=0 throughout.
- Hold `signal` high through reset release, then low 3 cycles and high 5 cycles: the first pulse is ignored, and the first result has `width`=5.
- With CW=4, drive high for 20 cycles then low: `width`=15, `sat`=1.
- Drive two pulses of width 2 and width 3 with no `ack`:
  - after the second fall, `width`=3 and `overrun`=1;
  - `ack` then gives `valid`=0 and `overrun`=0.
- Assert `ack` on the same edge as the second result load: `valid` stays 1, `width` takes the new value, and `overrun`=0.
- Assert `reset_n`=0 for one cycle in the middle of a 6-cycle high pulse:
  - no result is produced for that pulse;
  - the next full pulse reports correctly with `period_ok`=0.
